dcache_assoc: RTL

Parametrised set-associative, write-back, write-allocate data cache between the datapath's data-memory port and the memory controller (caches side). It generalises the fixed 2-way, 2-word-block data cache to configurable ways, sets and block size. It adds true-LRU replacement and a halt-triggered flush that writes back every dirty block. The flush finishes by storing the hit count to a fixed address.

---
 rtl/dcache_assoc.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with true-LRU replacement
// and a halt-triggered flush that finishes by storing the hit count to memory.
module dcache_assoc #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int unsigned BO = $clog2(BLOCK_WORDS);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 30 - BO - IW;
  localparam int unsigned OW = (BO > 0) ? BO : 1;
  localparam int unsigned AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, FLUSH_WB, CNT, DONE} state_t;

  state_t state_q, state_n;

  logic          valid_q [SETS][WAYS];
  logic          dirty_q [SETS][WAYS];
  logic [TW-1:0] tag_q   [SETS][WAYS];
  logic [AW-1:0] age_q   [SETS][WAYS];
  logic [31:0]   data_q  [SETS][WAYS][BLOCK_WORDS];

  logic [OW-1:0] wcnt_q;
  logic [AW-1:0] vic_q;
  logic [IW-1:0] midx_q;
  logic [TW-1:0] mtag_q;
  logic [IW-1:0] fset_q;
  logic [AW-1:0] fway_q;
  logic          miss_flag_q;
  logic [31:0]   hitcnt_q;

  logic [31:0]   req_wa;
  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          req;
  logic          hit_any;
  logic [AW-1:0] hit_way;
  logic [AW-1:0] vic_c;
  logic [AW-1:0] max_age;
  logic          vic_dirty;
  logic          last_word;
  logic          last_way;
  logic          last_line;
  logic          fl_dirty;
  logic [AW-1:0] fway_n;
  logic [IW-1:0] fset_n;

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                          input logic [OW-1:0] o);
    logic [29:0] w;
    w = (30'(t) << (IW + BO)) | (30'(i) << BO) | (30'(o) & 30'(BLOCK_WORDS - 1));
    return {w, 2'b00};
  endfunction

  // Request address decode
  assign req_wa  = dmemaddr >> 2;
  assign req_off = OW'(req_wa) & OW'(BLOCK_WORDS - 1);
  assign req_idx = IW'(req_wa >> BO);
  assign req_tag = TW'(req_wa >> (BO + IW));
  assign req     = dmemREN | dmemWEN;

  // Tag match and LRU victim (oldest way) for the requested set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    vic_c   = '0;
    max_age = age_q[req_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
      if (age_q[req_idx][w] > max_age) begin
        max_age = age_q[req_idx][w];
        vic_c   = AW'(w);
      end
    end
  end

  assign vic_dirty = valid_q[req_idx][vic_c] & dirty_q[req_idx][vic_c];
  assign last_word = (wcnt_q == OW'(BLOCK_WORDS - 1));
  assign last_way  = (fway_q == AW'(WAYS - 1));
  assign last_line = last_way && (fset_q == IW'(SETS - 1));
  assign fl_dirty  = valid_q[fset_q][fway_q] & dirty_q[fset_q][fway_q];
  assign fway_n    = last_way ? '0 : fway_q + AW'(1);
  assign fset_n    = last_way ? fset_q + IW'(1) : fset_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next state and all port outputs
  always_comb begin
    state_n  = state_q;
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) state_n = FLUSH;
        else if (req) begin
          if (hit_any) begin
            dhit     = 1'b1;
            dmemload = data_q[req_idx][hit_way][req_off];
          end else if (vic_dirty) state_n = WB;
          else state_n = ALLOC;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[midx_q][vic_q], midx_q, wcnt_q);
        dstore = data_q[midx_q][vic_q][wcnt_q];
        if (!dwait && last_word) state_n = ALLOC;
      end
      ALLOC: begin
        dREN  = 1'b1;
        daddr = mk_addr(mtag_q, midx_q, wcnt_q);
        if (!dwait && last_word) state_n = IDLE;
      end
      FLUSH: begin
        if (fl_dirty) state_n = FLUSH_WB;
        else if (last_line) state_n = CNT;
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[fset_q][fway_q], fset_q, wcnt_q);
        dstore = data_q[fset_q][fway_q][wcnt_q];
        if (!dwait && last_word) state_n = last_line ? CNT : FLUSH;
      end
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt_q;
        if (!dwait) state_n = DONE;
      end
      DONE:    flushed = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // Line metadata, LRU ages, transfer counters and hit counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q      <= '0;
      vic_q       <= '0;
      midx_q      <= '0;
      mtag_q      <= '0;
      fset_q      <= '0;
      fway_q      <= '0;
      miss_flag_q <= 1'b0;
      hitcnt_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          fset_q <= '0;
          fway_q <= '0;
          wcnt_q <= '0;
          if (!halt && req && !hit_any) begin
            vic_q       <= vic_c;
            midx_q      <= req_idx;
            mtag_q      <= req_tag;
            miss_flag_q <= 1'b1;
          end
          if (dhit) begin
            for (int w = 0; w < WAYS; w++) begin
              if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                age_q[req_idx][w] <= age_q[req_idx][w] + AW'(1);
            end
            age_q[req_idx][hit_way] <= '0;
            if (dmemWEN) dirty_q[req_idx][hit_way] <= 1'b1;
            // The first hit after a fill is the retried miss, not a new hit
            if (miss_flag_q) miss_flag_q <= 1'b0;
            else             hitcnt_q    <= hitcnt_q + 32'd1;
          end
        end
        WB: begin
          if (!dwait) wcnt_q <= last_word ? '0 : wcnt_q + OW'(1);
        end
        ALLOC: begin
          if (!dwait) begin
            wcnt_q <= last_word ? '0 : wcnt_q + OW'(1);
            if (last_word) begin
              valid_q[midx_q][vic_q] <= 1'b1;
              dirty_q[midx_q][vic_q] <= 1'b0;
              tag_q[midx_q][vic_q]   <= mtag_q;
            end
          end
        end
        FLUSH: begin
          if (!fl_dirty) begin
            fset_q <= fset_n;
            fway_q <= fway_n;
          end
        end
        FLUSH_WB: begin
          if (!dwait) begin
            wcnt_q <= last_word ? '0 : wcnt_q + OW'(1);
            if (last_word) begin
              dirty_q[fset_q][fway_q] <= 1'b0;
              fset_q <= fset_n;
              fway_q <= fway_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data array: write hits and fill words from memory
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && dhit && dmemWEN)
      data_q[req_idx][hit_way][req_off] <= dmemstore;
    if (state_q == ALLOC && !dwait)
      data_q[midx_q][vic_q][wcnt_q] <= dload;
  end

endmodule
